// File: rtl/mux8_arb_pkg.sv
// mux8_arb_pkg: shared constants, state encodings and helpers for mux8_rr_arbiter
package mux8_arb_pkg;
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction
endpackage

// File: rtl/arb_rr_pick8.sv
// arb_rr_pick8: combinational round-robin pick of the first set req bit starting at ptr
import mux8_arb_pkg::*;

module arb_rr_pick8 (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] winner
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;

    // Rotate so ptr lands at bit 0; the lowest set bit is then the offset from ptr
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N_REQ-1:0];

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) off = SEL_W'(i);
    end

    assign any    = |req;
    assign winner = ptr + off;
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin 8:1 word selector with registered valid/ready output and ack.
// Optional transfer counter (xfer_cnt, cnt_clr) enabled by defining MUX8_ARB_XFER_CNT_EN.
import mux8_arb_pkg::*;

module mux8_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef MUX8_ARB_XFER_CNT_EN
    input  logic                   cnt_clr,
    output logic [7:0]             xfer_cnt,
`endif
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] in_data,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic [SEL_W-1:0]       sel,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);
    logic [0:0]       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] win;
    logic             any;
    logic             hs;

    arb_rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (any),
        .winner (win)
    );

    assign hs  = out_valid && out_ready;
    assign ack = hs ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            grant     <= '0;
            sel       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (any) begin
                state     <= ST_XFER;
                sel       <= win;
                grant     <= onehot(win);
                out_data  <= in_data[int'(win)*WIDTH +: WIDTH];
                out_valid <= 1'b1;
                busy      <= 1'b1;
            end
        end else if (hs) begin
            state     <= ST_IDLE;
            grant     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= sel + SEL_W'(1);
        end
    end

`ifdef MUX8_ARB_XFER_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            xfer_cnt <= '0;
        else if (cnt_clr)
            xfer_cnt <= '0;
        else if (hs && xfer_cnt != 8'hFF)
            xfer_cnt <= xfer_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed plus randomized checks of mux8_rr_arbiter against a transfer-level model
module tb_mux8_rr_arbiter;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     req = '0;
    logic [8*W-1:0] in_data = '0;
    logic           out_ready = 1'b0;
    logic [7:0]     grant, ack;
    logic [2:0]     sel;
    logic [W-1:0]   out_data;
    logic           out_valid, busy;
`ifdef MUX8_ARB_XFER_CNT_EN
    logic           cnt_clr = 1'b0;
    logic [7:0]     xfer_cnt;
`endif

    int total = 0, bad = 0;
    logic [W-1:0] words [8];
    bit           m_busy;
    int           m_ptr, m_sel, m_cnt;
    logic [W-1:0] m_data;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUX8_ARB_XFER_CNT_EN
        .cnt_clr   (cnt_clr),
        .xfer_cnt  (xfer_cnt),
`endif
        .req       (req),
        .in_data   (in_data),
        .grant     (grant),
        .ack       (ack),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_words();
        for (int i = 0; i < 8; i++) in_data[i*W +: W] = words[i];
    endtask

    // Winner is the first requester found walking forward from the pointer
    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".grant"}, grant, m_busy ? (32'd1 << m_sel) : 32'd0);
        chk({tag, ".valid"}, out_valid, m_busy);
        chk({tag, ".busy"}, busy, m_busy);
        chk({tag, ".sel"}, sel, m_sel);
        chk({tag, ".data"}, out_data, m_data);
    endtask

    task automatic cyc(input string tag);
        #1;
        chk({tag, ".ack"}, ack, (m_busy && out_ready) ? (32'd1 << m_sel) : 32'd0);
        @(posedge clk);
        if (!m_busy) begin
            if (req != 0) begin
                m_sel  = pick(req, m_ptr);
                m_data = words[m_sel];
                m_busy = 1;
            end
        end else if (out_ready) begin
            m_busy = 0;
            m_ptr  = (m_sel + 1) % 8;
            m_cnt++;
        end
        @(negedge clk);
        check_outs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        m_busy = 0; m_ptr = 0; m_sel = 0; m_data = '0; m_cnt = 0;
        #1;
        check_outs(tag);
        chk({tag, ".ack"}, ack, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int seen [$];
        @(negedge clk);
        do_reset("rst");
        for (int i = 0; i < 10; i++) cyc("idle");

        words = '{4'd0, 4'd15, 4'd2, 4'd3, 4'd12, 4'd5, 4'd10, 4'd7};
        drive_words();
        req = 8'h02; out_ready = 1'b1;
        cyc("single");
        chk("single.sel1", sel, 32'd1);
        chk("single.data15", out_data, 32'd15);
        for (int i = 0; i < 7; i++) cyc("single");

        do_reset("rst2");
        req = 8'hFF;
        for (int i = 0; i < 18; i++) begin
            cyc("rr");
            if (out_valid && (seen.size() == 0 || i % 2 == 0)) seen.push_back(sel);
        end
        chk("rr.count", seen.size(), 32'd9);
        foreach (seen[k]) chk("rr.order", seen[k], k % 8);

        req = 8'h00;
        cyc("gap");
        req = 8'h10; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc("bp");
        chk("bp.data12", out_data, 32'd12);
        out_ready = 1'b1;
        cyc("bp.rel");
        req = 8'hFF;
        cyc("bp.next");
        chk("bp.ptr5", sel, 32'd5);
        cyc("bp.done");

        do_reset("rst3");
        req = 8'h80;
        cyc("wrap.h"); cyc("wrap.h");
        req = 8'h81;
        cyc("wrap.a");
        chk("wrap.a_first", sel, 32'd0);
        cyc("wrap.a");
        cyc("wrap.h2");
        chk("wrap.h_next", sel, 32'd7);
        cyc("wrap.h2");

        req = 8'hFF; out_ready = 1'b0;
        cyc("mid");
        chk("mid.valid", out_valid, 32'd1);
        do_reset("mid.rst");
        out_ready = 1'b1;
        cyc("mid.after");
        chk("mid.sel0", sel, 32'd0);

        for (int i = 0; i < 500; i++) begin
            for (int j = 0; j < 8; j++) words[j] = W'($urandom);
            drive_words();
            req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 80) == 0) do_reset("rnd.rst");
            cyc("rnd");
        end
`ifdef MUX8_ARB_XFER_CNT_EN
        chk("cnt", xfer_cnt, (m_cnt > 255) ? 32'd255 : m_cnt);
        cnt_clr = 1'b1; out_ready = 1'b1;
        cyc("clr");
        cnt_clr = 1'b0;
        chk("cnt.clr", xfer_cnt, 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter/scheduler that shares one 8:1 WIDTH-bit selection datapath among 8 requesters (a..h).
- Picks one requester, drives the 3-bit select, and captures the selected word into an output register.
- Presents the word downstream with a valid/ready handshake and returns a one-cycle ack to the winner.
- Sits between the eight data sources and a single downstream consumer.

Parameters:
- WIDTH, 4, bit width of each requester data word and of out_data.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request per source; bit0=a … bit7=h.
- in_data  input  8*WIDTH  packed source words; slice i = in_data[i*WIDTH +: WIDTH], i.e. a at LSBs.
- grant  output  8  one-hot current owner; 0 when idle.
- ack  output  8  one-hot, single-cycle; high on the handshake cycle for the owner.
- sel  output  3  registered select of the current/last owner ({sel2,sel1,sel0}).
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- busy  output  1  high in XFER.

Behaviour:
- Reset (async, rst_n=0) values:
  - Outputs: grant=0, ack=0, sel=0, out_data=0, out_valid=0, busy=0.
  - Internal: state=IDLE, rotation pointer ptr=0.
- FSM states: IDLE, XFER.
- IDLE:
  - If req != 0: winner = first set req bit scanning ptr, ptr+1, …, ptr+7 (mod 8).
  - Next edge registers sel=winner, grant=onehot(winner), out_data=slice(winner), out_valid=1, busy=1; state goes to XFER.
  - If req == 0: state and outputs hold.
- Latency: req seen at edge N → out_valid high after edge N.
- XFER:
  - out_data, sel and grant hold stable while out_valid=1 && out_ready=0. There is no timeout.
  - Handshake cycle (out_valid && out_ready): ack = grant, combinational. At the edge, out_valid=0, grant=0, busy=0, ptr=(sel+1) mod 8 (wrap 7→0), state goes to IDLE.
  - sel and out_data keep their last value after the handshake.
- Throughput: at most one transfer per 2 cycles; the IDLE bubble is intentional.
- Requester rules:
  - Data is captured at grant. The requester may change in_data after grant, but must keep req high until ack.
  - A requester that drops req during XFER still completes its transfer.
  - req changes during XFER affect only the next arbitration.
- All 8 requesting: service order is ptr, ptr+1, …, each requester exactly once per 8 transfers.
- A single persistent requester is re-granted every 2 cycles.
- Reset mid-transfer: the transfer is discarded, no ack is issued, ptr returns to 0.
- ack is never asserted outside XFER. ack and grant are never multi-hot.

Optional Feature:
- Macro: MUX8_ARB_XFER_CNT_EN.
- Defined:
  - Adds output xfer_cnt [7:0].
  - Increments on every handshake, saturates at 255, reset to 0.
  - Adds input cnt_clr; a synchronous clear that wins over a simultaneous increment.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Decomposition:
- Shared package/header mux8_arb_pkg:
  - N_REQ=8, SEL_W=3.
  - State encodings ST_IDLE=1'b0, ST_XFER=1'b1.
- Sub-module arb_rr_pick8 (combinational): inputs req[7:0] and ptr[2:0]; outputs any and winner[2:0].
- The top instantiates arb_rr_pick8 and indexes in_data directly by winner.

Test Plan:
- Reset/idle: rst_n=0 then 1, req=0 for 10 cycles → all outputs 0, busy=0.
- Single request: words a=0,b=15,c=2,d=3,e=12,f=5,g=10,h=7; req=8'b0000_0010, out_ready=1 → one cycle later sel=1, out_data=15, grant=8'h02; ack=8'h02 for exactly 1 cycle; repeats every 2 cycles.
- Round-robin fairness: req=8'hFF, out_ready=1 → sel sequence 0,1,…,7,0 and out_data sequence 0,15,2,3,12,5,10,7,0.
- Backpressure: req=8'h10 with out_ready=0 for 5 cycles → out_valid=1, out_data=12, sel=4 stable, ack=0. Then out_ready=1 → ack=8'h10 for 1 cycle, next ptr=5.
- Wrap and skip: after serving h (ptr=0), req=8'h81 → a (sel=0) served before h. After a, ptr=1 → h (sel=7) is the next winner.
- Reset mid-XFER: rst_n low while out_valid=1 → outputs clear immediately (asynchronously), no ack. Next arbitration with req=8'hFF picks sel=0.
